// File: rtl/qupls4_backout_sequencer_if.sv
// Handshake bundle between the branch-resolution logic, the backout
// sequencer and the RAT restore port.
//   backout/br_rid/rob_tail : backout request and the ROB window it covers
//   flush                   : pipeline flush, aborts any walk in progress
//   rat_rdy                 : RAT accepts a restore this cycle
//   restore/restore_rid     : restore request and the ROB entry to back out
//   busy/done               : sequencer activity and completion pulse
// modport slave is the sequencer; modport master is its environment.
interface qupls4_backout_sequencer_if #(
    parameter int ROBW = 4
);
    logic            backout;
    logic [ROBW-1:0] br_rid;
    logic [ROBW-1:0] rob_tail;
    logic            flush;
    logic            rat_rdy;
    logic            restore;
    logic [ROBW-1:0] restore_rid;
    logic            busy;
    logic            done;

    modport master (
        output backout, br_rid, rob_tail, flush, rat_rdy,
        input  restore, restore_rid, busy, done
    );

    modport slave (
        input  backout, br_rid, rob_tail, flush, rat_rdy,
        output restore, restore_rid, busy, done
    );
endinterface

// File: rtl/qupls4_backout_sequencer.sv
// Walks the ROB from the youngest entry down to the entry just after a
// resolved branch, asking the RAT to back out each destination mapping,
// one per accepted restore handshake.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : qupls4_backout_sequencer_if.slave (request, RAT handshake, status)
// Status outputs are flops loaded from the next-state decode, so they are
// glitch-free and follow state exactly.
module qupls4_backout_sequencer #(
    parameter int ROB_ENTRIES = 16,
    parameter int ROBW        = $clog2(ROB_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          rst,
    qupls4_backout_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ROBW-1:0] ONE_C  = {{(ROBW-1){1'b0}}, 1'b1};
    localparam logic [ROBW-1:0] ZERO_C = {ROBW{1'b0}};

    state_t          state_r;
    state_t          state_s;
    logic [ROBW-1:0] cnt_r;
    logic [ROBW-1:0] cnt_s;
    logic [ROBW-1:0] ptr_r;
    logic [ROBW-1:0] ptr_s;
    logic            restore_r;
    logic            done_r;
    logic            busy_r;

    // Next-state, walk counter and walk pointer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ptr_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (bus.flush) begin
                    state_s = IDLE;
                end else if (bus.backout) begin
                    // Entries strictly younger than the branch. Natural ROBW-bit
                    // wrap makes rob_tail == br_rid mean a full ROB.
                    cnt_s = bus.rob_tail - bus.br_rid - ONE_C;
                    ptr_s = bus.rob_tail - ONE_C;
                    if (cnt_s != ZERO_C) begin
                        state_s = WALK;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WALK: begin
                // restore is high throughout WALK, so rat_rdy alone is the accept.
                if (bus.rat_rdy) begin
                    ptr_s = ptr_r - ONE_C;
                    cnt_s = cnt_r - ONE_C;
                    if (cnt_r == ONE_C) begin
                        state_s = DONE;
                    end else begin
                        state_s = WALK;
                    end
                end else begin
                    state_s = WALK;
                end
                // A flush still lets this cycle's accept update ptr/cnt above.
                if (bus.flush) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_s;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, walk registers and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= ZERO_C;
            ptr_r     <= ZERO_C;
            restore_r <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            ptr_r     <= ptr_s;
            restore_r <= (state_s == WALK);
            done_r    <= (state_s == DONE);
            busy_r    <= (state_s != IDLE);
        end
    end

    assign bus.restore     = restore_r;
    assign bus.restore_rid = ptr_r;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_qupls4_backout_sequencer.sv
// Self-checking bench for qupls4_backout_sequencer (ROB_ENTRIES = 16).
// A queue-based model holds the ROB ids still to be restored and a pending
// done flag; it is compared against the DUT on every falling edge. Directed
// scenarios additionally check hand-computed restore sequences.
module tb_qupls4_backout_sequencer;
    localparam int N = 16;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    qupls4_backout_sequencer_if #(.ROBW(W)) bus ();

    qupls4_backout_sequencer #(.ROB_ENTRIES(N), .ROBW(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_q[$];
    bit m_done = 1'b0;

    // Monitor logs
    int acc_q[$];
    int done_cnt = 0;
    int busy_cnt = 0;
    int hold2_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_list(input string name, input int exp[$]);
        chk({name, "_count"}, acc_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
            chk($sformatf("%s_rid%0d", name, i), acc_q[i], exp[i]);
    endtask

    // Model: what remains of the walk, advanced on each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (bus.flush) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() != 0) begin
            if (bus.rat_rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (bus.backout) begin
            int n;
            n = ((int'(bus.rob_tail) - int'(bus.br_rid) - 1) % N + N) % N;
            if (int'(bus.rob_tail) == int'(bus.br_rid)) n = N - 1;
            for (int k = 0; k < n; k++)
                m_q.push_back(((int'(bus.rob_tail) - 1 - k) % N + N) % N);
            if (n == 0) m_done = 1'b1;
        end
    end

    // Compare DUT against the model, and log accepted restores.
    always @(negedge clk) begin
        chk("restore", bus.restore, (m_q.size() != 0));
        chk("done", bus.done, m_done);
        chk("busy", bus.busy, (m_q.size() != 0) || m_done);
        if (m_q.size() != 0) chk("restore_rid", bus.restore_rid, m_q[0]);
        if (bus.restore && bus.rat_rdy) acc_q.push_back(int'(bus.restore_rid));
        if (bus.restore && bus.restore_rid == 4'd2) hold2_cnt++;
        if (bus.done) done_cnt++;
        if (bus.busy) busy_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        hold2_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            step();
        end
        if (i >= 40) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic start(input logic [3:0] br, input logic [3:0] tail);
        bus.backout  = 1'b1;
        bus.br_rid   = br;
        bus.rob_tail = tail;
        step();
        bus.backout  = 1'b0;
    endtask

    initial begin
        bus.backout  = 1'b0;
        bus.br_rid   = 4'd0;
        bus.rob_tail = 4'd0;
        bus.flush    = 1'b0;
        bus.rat_rdy  = 1'b1;
        step();
        step();
        chk("rst_restore", bus.restore, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        rst = 1'b0;
        step();

        // Basic walk: 6,5,4 then done
        clear_logs();
        start(4'd3, 4'd7);
        wait_idle("basic");
        chk_list("basic", '{6, 5, 4});
        chk("basic_done", done_cnt, 1);
        chk("basic_busy_cycles", busy_cnt, 4);
        step();

        // Wrap through index 0
        clear_logs();
        start(4'd14, 4'd2);
        wait_idle("wrap");
        chk_list("wrap", '{1, 0, 15});
        chk("wrap_done", done_cnt, 1);
        step();

        // Empty walk
        clear_logs();
        start(4'd5, 4'd6);
        chk("empty_done_now", bus.done, 1'b1);
        wait_idle("empty");
        chk("empty_restores", acc_q.size(), 0);
        chk("empty_busy_cycles", busy_cnt, 1);
        step();

        // Full ROB: rob_tail == br_rid
        clear_logs();
        start(4'd4, 4'd4);
        wait_idle("full");
        chk("full_count", acc_q.size(), 15);
        if (acc_q.size() == 15) begin
            chk("full_first", acc_q[0], 3);
            chk("full_wrap", acc_q[4], 15);
            chk("full_last", acc_q[14], 5);
        end
        chk("full_done", done_cnt, 1);
        step();

        // Back-pressure on the first request
        clear_logs();
        bus.rat_rdy = 1'b0;
        start(4'd0, 4'd3);
        step();
        step();
        bus.rat_rdy = 1'b1;
        wait_idle("bp");
        chk_list("bp", '{2, 1});
        chk("bp_hold", hold2_cnt, 3);
        chk("bp_done", done_cnt, 1);
        step();

        // Flush during the second restore of a 4-entry walk
        clear_logs();
        start(4'd2, 4'd7);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_restore", bus.restore, 1'b0);
        start(4'd9, 4'd11);
        chk("flush_new_restore", bus.restore, 1'b1);
        wait_idle("flush");
        chk_list("flush", '{6, 5, 10});
        chk("flush_done", done_cnt, 1);
        step();

        // Async reset mid-walk, backout ignored under reset
        clear_logs();
        start(4'd0, 4'd8);
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_restore", bus.restore, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        step();
        bus.backout  = 1'b1;
        bus.br_rid   = 4'd3;
        bus.rob_tail = 4'd7;
        step();
        step();
        chk("arst_ignore_busy", bus.busy, 1'b0);
        clear_logs();
        rst = 1'b0;
        step();
        bus.backout = 1'b0;
        chk("arst_first_edge", bus.restore, 1'b1);
        wait_idle("arst");
        chk_list("arst", '{6, 5, 4});
        chk("arst_done_cnt", done_cnt, 1);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qupls4_backout_sequencer.md
QUPLS4_BACKOUT_SEQUENCER -- requirements
Module: Qupls4_backout_sequencer

Interface
REQ-001 Parameter ROB_ENTRIES, default 16, ROB depth; SHALL be a power of two, at least 4.
REQ-002 Parameter ROBW, default $clog2(ROB_ENTRIES), width of a ROB index.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 backout  input  1  single-cycle request to back out register mappings younger than a resolved branch.
REQ-006 br_rid  input  ROBW  ROB index of the resolving branch; sampled with backout.
REQ-007 rob_tail  input  ROBW  ROB tail (next free entry); sampled with backout.
REQ-008 flush  input  1  pipeline flush; aborts any walk.
REQ-009 rat_rdy  input  1  RAT accepts a restore this cycle.
REQ-010 restore  output  1  restore request valid.
REQ-011 restore_rid  output  ROBW  ROB entry whose destination mapping the RAT SHALL back out.
REQ-012 busy  output  1  high in any state other than IDLE; stalls rename.
REQ-013 done  output  1  one-cycle pulse when a walk completes normally.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WALK and DONE.
REQ-015 In IDLE with backout=1 and flush=0, the block SHALL latch cnt = (rob_tail - br_rid - 1) mod ROB_ENTRIES and ptr = (rob_tail - 1) mod ROB_ENTRIES.
REQ-016 In the same IDLE case, the next state SHALL be WALK if cnt != 0, else DONE.
REQ-017 All index arithmetic SHALL be modulo ROB_ENTRIES in ROBW bits; wrap-around through index 0 SHALL be seamless.
REQ-018 rob_tail == br_rid SHALL be treated as a full ROB, giving cnt = ROB_ENTRIES-1.
REQ-019 In WALK, restore SHALL be 1 and restore_rid SHALL equal ptr; the walk order is youngest to oldest.
REQ-020 restore and restore_rid SHALL hold stable until rat_rdy=1 (valid/ready handshake).
REQ-021 On each cycle with restore=1 and rat_rdy=1, ptr SHALL decrement by 1 (mod ROB_ENTRIES) and cnt SHALL decrement by 1.
REQ-022 If that accept takes cnt from 1 to 0, the next state SHALL be DONE.
REQ-023 Throughput SHALL be one restore per cycle while rat_rdy stays high.
REQ-024 The first restore SHALL be asserted on the cycle after backout is sampled (latency 1).
REQ-025 DONE SHALL last exactly one cycle, with done=1 and restore=0, and SHALL then return to IDLE.
REQ-026 backout asserted in WALK or DONE SHALL be ignored (not queued); the issuer guarantees this does not occur while busy=1.
REQ-027 flush=1 in any state SHALL force IDLE on the next edge with no done pulse; a restore accepted in that same cycle SHALL still count as accepted.
REQ-028 flush and backout together in IDLE: flush SHALL win and nothing is latched.
REQ-029 restore SHALL be 0 in IDLE and DONE; busy SHALL equal (state != IDLE).
REQ-030 restore_rid SHALL be driven from ptr in all states; it is don't-care when restore=0.

Reset
REQ-031 While rst=1, state SHALL be IDLE, cnt=0, ptr=0, restore=0, done=0 and busy=0, independent of clk.
REQ-032 Reset asserted mid-walk SHALL abandon the walk with no further restore or done.
REQ-033 After rst deasserts, the block SHALL accept backout on the first rising edge.

Verification
REQ-034 ROB_ENTRIES=16, br_rid=3, rob_tail=7, rat_rdy=1 -> restore_rid 6,5,4 on consecutive cycles, then done=1 for one cycle, then busy=0.
REQ-035 Wrap case: br_rid=14, rob_tail=2 -> restore_rid 1,0,15, then done; exactly 3 restores.
REQ-036 Empty case: br_rid=5, rob_tail=6 -> no restore; done=1 on the cycle after backout; busy high for one cycle only.
REQ-037 Back-pressure: br_rid=0, rob_tail=3, rat_rdy low for 2 cycles on the first request -> restore_rid=2 held 3 cycles, then 1, then done; total restores 2.
REQ-038 Abort: flush during the second restore of a 4-entry walk -> IDLE on the next cycle, no done, no further restore; a new backout is accepted the following cycle.
REQ-039 Async reset asserted mid-walk between clock edges -> restore=0 and busy=0 immediately; a backout pulse while rst=1 is ignored.
